ama_riscv_mem_arbiter: RTL

Shared backing-memory port arbiter directly downstream of the icache and dcache. Accepts the icache line-read channel, the dcache line-read channel and the dcache line-write (data+address) channel. Serialises them onto one memory request/response port and routes read data back to the originating cache. One transaction is in flight at a time; writes are posted (no response to the cache).

---
 rtl/ama_riscv_mem_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter: serialises icache/dcache line traffic onto one memory port, one transaction at a time
module ama_riscv_mem_arbiter #(
  parameter int AW = 26,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_imem_valid,
  output logic          req_imem_ready,
  input  logic [AW-1:0] req_imem_data,
  output logic          rsp_imem_valid,
  input  logic          rsp_imem_ready,
  output logic [DW-1:0] rsp_imem_data,
  input  logic          req_dmem_r_valid,
  output logic          req_dmem_r_ready,
  input  logic [AW-1:0] req_dmem_r_data,
  input  logic          req_dmem_w_valid,
  output logic          req_dmem_w_ready,
  input  logic [AW-1:0] req_dmem_w_addr,
  input  logic [DW-1:0] req_dmem_w_data,
  output logic          rsp_dmem_valid,
  input  logic          rsp_dmem_ready,
  output logic [DW-1:0] rsp_dmem_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
  state_t state, state_nxt;
  logic last_d, src_i, idle, d_pend, grant, rsp_hs, rsp_cap;
  always_comb begin
    idle = state == IDLE;
    d_pend = req_dmem_w_valid | req_dmem_r_valid;
    // last_d set means the D group was granted last, so icache wins a tie
    req_imem_ready = idle & req_imem_valid & (~d_pend | last_d);
    req_dmem_w_ready = idle & req_dmem_w_valid & ~req_imem_ready;
    req_dmem_r_ready = idle & req_dmem_r_valid & ~req_dmem_w_valid & ~req_imem_ready;
    grant = req_imem_ready | req_dmem_w_ready | req_dmem_r_ready;
    mem_req_valid = state == ISSUE;
    rsp_imem_valid = (state == RSP) & src_i;
    rsp_dmem_valid = (state == RSP) & ~src_i;
    rsp_hs = src_i ? rsp_imem_ready : rsp_dmem_ready;
    rsp_cap = (state == WAIT) & mem_rsp_valid;
    state_nxt = idle ? (grant ? ISSUE : IDLE) :
                (state == ISSUE) ? (mem_req_ready ? (mem_req_we ? IDLE : WAIT) : ISSUE) :
                (state == WAIT) ? (mem_rsp_valid ? RSP : WAIT) :
                (rsp_hs ? IDLE : RSP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_d <= 1'b1;
      src_i <= 1'b0;
      mem_req_we <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      rsp_imem_data <= '0;
      rsp_dmem_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_d <= ~req_imem_ready;
        src_i <= req_imem_ready;
        mem_req_we <= req_dmem_w_ready;
        mem_req_addr <= req_imem_ready ? req_imem_data : req_dmem_w_ready ? req_dmem_w_addr : req_dmem_r_data;
        mem_req_wdata <= req_dmem_w_ready ? req_dmem_w_data : '0;
      end
      if (rsp_cap & src_i) rsp_imem_data <= mem_rsp_data;
      if (rsp_cap & ~src_i) rsp_dmem_data <= mem_rsp_data;
    end
  end
endmodule
